// File: rtl/rs_pkg.sv
// Shared Reed-Solomon definitions for the CIRC encode and syndrome paths.
// GF(2^8) with primitive polynomial 0x11D, generator roots alpha^0..alpha^3.
package rs_pkg;

  localparam logic [8:0] RS_PRIM_POLY = 9'h11D;
  localparam int         RS_NPAR      = 4;

  localparam logic [7:0] RS_G3 = 8'h0F;
  localparam logic [7:0] RS_G2 = 8'h36;
  localparam logic [7:0] RS_G1 = 8'h78;
  localparam logic [7:0] RS_G0 = 8'h40;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } rs_state_t;

  // With a constant c this folds into a pure XOR network.
  function automatic logic [7:0] gf_mul_const(
    input logic [7:0] a,
    input logic [7:0] c
  );
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? RS_PRIM_POLY[7:0] : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_gf_mul_const.sv
// Constant-coefficient GF(2^8) multiplier: y = a * COEF.
// Pure combinational XOR network.
module rs_gf_mul_const
  import rs_pkg::*;
#(
  parameter logic [7:0] COEF = 8'h01
) (
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = gf_mul_const(a, COEF);

endmodule

// File: rtl/rs_enc_parity_gen.sv
// Systematic RS(P_K+4,P_K) parity generator: message pass-through, then 4 parity bytes.
// Define RS_ENC_PARITY_INV_EN to emit parity bit-inverted (CIRC P/Q style).
module rs_enc_parity_gen
  import rs_pkg::*;
#(
  parameter int P_K = 24
) (
  input  logic       i_clk,
  input  logic       i_resb,
  input  logic       i_frame_sync,
  input  logic [7:0] i_data,
  input  logic       i_data_sync,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_sync
);

  localparam logic [7:0] K_LAST = 8'(P_K - 1);
  localparam logic [1:0] P_LAST = 2'(RS_NPAR - 1);

  rs_state_t  state;
  rs_state_t  state_nxt;
  logic [7:0] r3, r2, r1, r0;
  logic [7:0] cnt;
  logic [1:0] pcnt;

  logic       restart;
  logic       accept;
  logic       last;
  logic [7:0] idx;
  logic [7:0] b3, b2, b1, b0;
  logic [7:0] f;
  logic [7:0] m3, m2, m1, m0;
  logic [7:0] par;

  // A frame sync mid-parity is ignored so the parity always completes.
  assign restart = i_frame_sync && (state != PARITY);
  assign accept  = i_data_sync && (restart || state == DATA);
  assign idx     = restart ? 8'd0 : cnt;
  assign last    = (idx == K_LAST);

  assign b3 = restart ? 8'd0 : r3;
  assign b2 = restart ? 8'd0 : r2;
  assign b1 = restart ? 8'd0 : r1;
  assign b0 = restart ? 8'd0 : r0;
  assign f  = i_data ^ b3;

  rs_gf_mul_const #(.COEF(RS_G3)) u_mul3 (.a(f), .y(m3));
  rs_gf_mul_const #(.COEF(RS_G2)) u_mul2 (.a(f), .y(m2));
  rs_gf_mul_const #(.COEF(RS_G1)) u_mul1 (.a(f), .y(m1));
  rs_gf_mul_const #(.COEF(RS_G0)) u_mul0 (.a(f), .y(m0));

`ifdef RS_ENC_PARITY_INV_EN
  assign par = ~r3;
`else
  assign par = r3;
`endif

  assign o_ready = (state == DATA);

  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (restart) state_nxt = (accept && last) ? PARITY : DATA;
      end
      DATA: begin
        if (accept && last) state_nxt = PARITY;
      end
      PARITY: begin
        if (pcnt == P_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      r3      <= '0;
      r2      <= '0;
      r1      <= '0;
      r0      <= '0;
      cnt     <= '0;
      pcnt    <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_sync  <= 1'b0;
    end else if (state == PARITY) begin
      o_data  <= par;
      o_valid <= 1'b1;
      o_sync  <= 1'b0;
      r3      <= r2;
      r2      <= r1;
      r1      <= r0;
      r0      <= '0;
      pcnt    <= pcnt + 2'd1;
    end else if (accept) begin
      r3      <= b2 ^ m3;
      r2      <= b1 ^ m2;
      r1      <= b0 ^ m1;
      r0      <= m0;
      cnt     <= last ? 8'd0 : idx + 8'd1;
      pcnt    <= '0;
      o_data  <= i_data;
      o_valid <= 1'b1;
      o_sync  <= (idx == 8'd0);
    end else begin
      o_valid <= 1'b0;
      o_sync  <= 1'b0;
      if (restart) begin
        r3  <= '0;
        r2  <= '0;
        r1  <= '0;
        r0  <= '0;
        cnt <= '0;
      end
    end
  end

endmodule
